// File: rtl/frame_sequencer.sv
// Double-buffered 8x8 frame store with a small register file, manual/auto
// back-to-front swaps synchronised to the driver's frame_done pulse.
`timescale 1ns/1ps
module frame_sequencer #(
    parameter bit AUTO_DEFAULT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic [3:0]  rd_addr,
    output logic [7:0]  rd_data,
    input  logic        frame_done,
    output logic [63:0] frame_out,
    output logic [5:0]  done_index,
    output logic        swap_pending
);

    localparam int unsigned ROWS = 8;
    localparam int unsigned RW   = 8;

    typedef enum logic [1:0] {IDLE, CLEAR, PENDING} state_t;

    state_t          state;
    logic [RW-1:0]   back [ROWS];
    logic [63:0]     front;
    logic [63:0]     back_flat;
    logic [5:0]      didx;
    logic [RW-1:0]   interval;
    logic [RW-1:0]   fcount;
    logic [RW-1:0]   icnt;
    logic            auto_swap;
    logic [2:0]      clr_idx;
    logic            wr_fire;
    logic            auto_hit;
    logic            icnt_last;

    assign wr_fire    = wr_valid && wr_ready;
    assign auto_hit   = (state == IDLE) && auto_swap && frame_done;
    // INTERVAL of 0 behaves as 1: swap on every frame
    assign icnt_last  = (interval == 8'd0) ? (icnt == 8'd0) : (icnt == interval - 8'd1);
    assign frame_out  = front;
    assign done_index = didx;

    always_comb begin
        back_flat = '0;
        for (int i = 0; i < int'(ROWS); i++) begin
            back_flat[i*8 +: 8] = back[i];
        end
    end

    always_comb begin
        rd_data = '0;
        if (!rd_addr[3]) begin
            rd_data = back[rd_addr[2:0]];
        end else begin
            case (rd_addr[2:0])
                3'd0:    rd_data = {6'd0, auto_swap, 1'b0};
                3'd1:    rd_data = {2'd0, didx};
                3'd2:    rd_data = interval;
                3'd3:    rd_data = fcount;
                default: rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ready     <= 1'b1;
            swap_pending <= 1'b0;
            for (int i = 0; i < int'(ROWS); i++) begin
                back[i] <= '0;
            end
            front        <= '0;
            didx         <= '0;
            interval     <= '0;
            fcount       <= '0;
            icnt         <= '0;
            auto_swap    <= AUTO_DEFAULT;
            clr_idx      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Swap samples back before any same-cycle write lands
                    if (auto_hit) begin
                        if (icnt_last) begin
                            front  <= back_flat;
                            fcount <= fcount + 8'd1;
                            icnt   <= '0;
                        end else begin
                            icnt   <= icnt + 8'd1;
                        end
                    end
                    if (wr_fire) begin
                        if (!wr_addr[3]) begin
                            back[wr_addr[2:0]] <= wr_data;
                        end else if (wr_addr == 4'd8) begin
                            auto_swap <= wr_data[1];
                            if (!wr_data[1]) begin
                                icnt <= '0;
                            end
                            if (wr_data[2]) begin
                                state    <= CLEAR;
                                wr_ready <= 1'b0;
                                clr_idx  <= '0;
                            end else if (wr_data[0]) begin
                                state        <= PENDING;
                                wr_ready     <= 1'b0;
                                swap_pending <= 1'b1;
                            end
                        end else if (wr_addr == 4'd9) begin
                            didx <= wr_data[5:0];
                        end else if (wr_addr == 4'd10) begin
                            interval <= wr_data;
                        end
                    end
                end
                CLEAR: begin
                    back[clr_idx] <= '0;
                    clr_idx       <= clr_idx + 3'd1;
                    if (clr_idx == 3'd7) begin
                        state    <= IDLE;
                        wr_ready <= 1'b1;
                    end
                end
                PENDING: begin
                    if (frame_done) begin
                        front        <= back_flat;
                        fcount       <= fcount + 8'd1;
                        state        <= IDLE;
                        wr_ready     <= 1'b1;
                        swap_pending <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    wr_ready     <= 1'b1;
                    swap_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed scenarios plus randomized traffic for frame_sequencer, checked
// against a behavioural model of the register/swap rules.
`timescale 1ns/1ps
module tb_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [3:0]  rd_addr = '0;
    logic [7:0]  rd_data;
    logic        frame_done = 1'b0;
    logic [63:0] frame_out;
    logic [5:0]  done_index;
    logic        swap_pending;

    int checks = 0;
    int errors = 0;

    frame_sequencer #(.AUTO_DEFAULT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_done(frame_done), .frame_out(frame_out),
        .done_index(done_index), .swap_pending(swap_pending)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  back_m [8];
    logic [63:0] m_front;
    logic [5:0]  m_didx;
    logic [7:0]  m_interval;
    logic [7:0]  m_fcount;
    logic [7:0]  m_frames;
    logic        m_auto;
    logic        m_pending;
    int          m_clr_left;

    function automatic logic [63:0] m_pack();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = back_m[i];
        return r;
    endfunction

    function automatic logic [7:0] m_read(input logic [3:0] a);
        if (a < 4'd8) return back_m[a[2:0]];
        case (a)
            4'd8:    return {6'd0, m_auto, 1'b0};
            4'd9:    return {2'd0, m_didx};
            4'd10:   return m_interval;
            4'd11:   return m_fcount;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic m_ready();
        return !m_pending && (m_clr_left == 0);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) back_m[i] = '0;
        m_front = '0; m_didx = '0; m_interval = '0; m_fcount = '0;
        m_frames = '0; m_auto = 1'b0; m_pending = 1'b0; m_clr_left = 0;
    endtask

    task automatic m_swap();
        m_front  = m_pack();
        m_fcount = m_fcount + 8'd1;
    endtask

    // One clock of behaviour, using the state visible before the edge
    task automatic m_step(input logic v, input logic [3:0] a, input logic [7:0] d, input logic fd);
        logic       rdy;
        logic [7:0] period;
        rdy = m_ready();
        if (m_clr_left != 0) begin
            back_m[3'(8 - m_clr_left)] = '0;
            m_clr_left--;
        end else if (m_pending) begin
            if (fd) begin
                m_swap();
                m_pending = 1'b0;
            end
        end else begin
            if (fd && m_auto) begin
                period   = (m_interval == 8'd0) ? 8'd1 : m_interval;
                m_frames = m_frames + 8'd1;
                if (m_frames == period) begin
                    m_swap();
                    m_frames = '0;
                end
            end
            if (v && rdy) begin
                if (a < 4'd8) back_m[a[2:0]] = d;
                else if (a == 4'd8) begin
                    m_auto = d[1];
                    if (!d[1]) m_frames = '0;
                    if (d[2]) m_clr_left = 8;
                    else if (d[0]) m_pending = 1'b1;
                end
                else if (a == 4'd9)  m_didx = d[5:0];
                else if (a == 4'd10) m_interval = d;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs();
        logic [3:0] ra;
        ra = 4'($urandom_range(0, 15));
        rd_addr = ra;
        #1;
        chk("frame_out", frame_out, m_front);
        chk("swap_pending", 64'(swap_pending), 64'(m_pending));
        chk("wr_ready", 64'(wr_ready), 64'(m_ready()));
        chk("done_index", 64'(done_index), 64'(m_didx));
        chk("rd_data", 64'(rd_data), 64'(m_read(ra)));
    endtask

    task automatic step(input logic v, input logic [3:0] a, input logic [7:0] d, input logic fd);
        wr_valid = v; wr_addr = a; wr_data = d; frame_done = fd;
        m_step(v, a, d, fd);
        @(posedge clk); #1;
        wr_valid = 1'b0; frame_done = 1'b0;
        chk_outputs();
    endtask

    task automatic do_reset(input logic fd);
        rst = 1'b1; frame_done = fd; wr_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; frame_done = 1'b0;
        m_reset();
        chk("rst_frame_out", frame_out, 64'd0);
        chk("rst_done_index", 64'(done_index), 64'd0);
        chk("rst_swap_pending", 64'(swap_pending), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        chk_outputs();
    endtask

    // Idle-cycle register read; only used while nothing is in flight
    task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = a;
        #1;
        chk(tag, 64'(rd_data), 64'(exp));
    endtask

    initial begin
        int cnt;
        int pend_seen;
        logic [3:0] ra;
        logic [7:0] rdv;

        m_reset();
        do_reset(1'b0);
        do_reset(1'b1);

        // Manual swap
        for (int i = 0; i < 8; i++) step(1'b1, 4'(i), 8'(i + 1), 1'b0);
        step(1'b1, 4'd9, 8'hE5, 1'b0);
        chk("didx_write", 64'(done_index), 64'h25);
        step(1'b1, 4'd8, 8'h01, 1'b0);
        chk("commit_pending", 64'(swap_pending), 64'd1);
        step(1'b0, 4'd0, 8'h00, 1'b0);
        step(1'b0, 4'd0, 8'h00, 1'b1);
        chk("manual_frame", frame_out, 64'h0807060504030201);
        chk("manual_pending_low", 64'(swap_pending), 64'd0);
        read_chk("manual_fcount", 4'd11, 8'd1);

        // Stall: write held off while a commit waits
        step(1'b1, 4'd0, 8'h11, 1'b0);
        step(1'b1, 4'd8, 8'h01, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'd0, 8'hFF, 1'b0);
            chk("stall_ready", 64'(wr_ready), 64'd0);
        end
        step(1'b1, 4'd0, 8'hFF, 1'b1);
        step(1'b1, 4'd0, 8'hFF, 1'b0);
        chk("stall_front_row0", 64'(frame_out[7:0]), 64'h11);
        read_chk("stall_back_row0", 4'd0, 8'hFF);

        // Clear with commit in the same write
        for (int i = 0; i < 8; i++) step(1'b1, 4'(i), 8'hAA, 1'b0);
        step(1'b1, 4'd8, 8'h05, 1'b0);
        cnt = 0; pend_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (wr_ready === 1'b0) cnt++;
            if (swap_pending === 1'b1) pend_seen++;
            step(1'b0, 4'd0, 8'h00, i == 3);
        end
        chk("clear_busy_cycles", 64'(cnt), 64'd8);
        chk("clear_no_pending", 64'(pend_seen), 64'd0);
        for (int i = 0; i < 8; i++) read_chk("clear_row", 4'(i), 8'h00);
        read_chk("clear_fcount", 4'd11, 8'd2);

        // Commit coincident with frame_done
        step(1'b1, 4'd1, 8'h5A, 1'b0);
        step(1'b1, 4'd8, 8'h01, 1'b1);
        chk("simul_pending", 64'(swap_pending), 64'd1);
        read_chk("simul_fcount_hold", 4'd11, 8'd2);
        step(1'b0, 4'd0, 8'h00, 1'b1);
        chk("simul_swap", 64'(frame_out[15:8]), 64'h5A);
        read_chk("simul_fcount", 4'd11, 8'd3);

        // Auto mode, INTERVAL=3
        do_reset(1'b0);
        step(1'b1, 4'd3, 8'h3C, 1'b0);
        step(1'b1, 4'd10, 8'd3, 1'b0);
        step(1'b1, 4'd8, 8'h02, 1'b0);
        for (int p = 1; p <= 7; p++) begin
            step(1'b0, 4'd0, 8'h00, 1'b1);
            step(1'b0, 4'd0, 8'h00, 1'b0);
        end
        read_chk("auto_fcount7", 4'd11, 8'd2);
        chk("auto_front", 64'(frame_out[31:24]), 64'h3C);
        step(1'b0, 4'd0, 8'h00, 1'b1);
        read_chk("auto_fcount8", 4'd11, 8'd2);
        step(1'b0, 4'd0, 8'h00, 1'b1);
        read_chk("auto_fcount9", 4'd11, 8'd3);

        // Reset while a commit is pending
        step(1'b1, 4'd8, 8'h00, 1'b0);
        step(1'b1, 4'd8, 8'h01, 1'b0);
        step(1'b0, 4'd0, 8'h00, 1'b0);
        do_reset(1'b1);
        step(1'b0, 4'd0, 8'h00, 1'b1);
        chk("abort_frame_out", frame_out, 64'd0);
        read_chk("abort_fcount", 4'd11, 8'd0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            ra  = 4'($urandom_range(0, 15));
            rdv = 8'($urandom);
            if (ra == 4'd8 && $urandom_range(0, 3) != 0) rdv[2] = 1'b0;
            if (ra == 4'd10) rdv = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 299) == 0)
                do_reset(1'($urandom_range(0, 1)));
            else
                step(1'($urandom_range(0, 1)), ra, rdv, $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have parameter: AUTO_DEFAULT, 0, reset value of CTRL.auto_swap.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: wr_valid  in  1  register-write request from SPI slave.
REQ-005 SHALL have port: wr_ready  out  1  write accepted this cycle when wr_valid and wr_ready are both high.
REQ-006 SHALL have port: wr_addr  in  4  register address.
REQ-007 SHALL have port: wr_data  in  8  write data.
REQ-008 SHALL have port: rd_addr  in  4  readback address, combinational read.
REQ-009 SHALL have port: rd_data  out  8  readback data.
REQ-010 SHALL have port: frame_done  in  1  one-cycle pulse from the charlieplex driver at the end of each displayed frame.
REQ-011 SHALL have port: frame_out  out  64  front buffer as {row7..row0}, row0 in bits [7:0], to the driver.
REQ-012 SHALL have port: done_index  out  6  frame-length config to the driver; equals DIDX[5:0].
REQ-013 SHALL have port: swap_pending  out  1  a manual commit is waiting for frame_done.

Function
REQ-014 SHALL implement this register map:
- 0-7: back-buffer rows, R/W.
- 8: CTRL, with bit0 commit (write-1 pulse, reads 0), bit1 auto_swap, bit2 clear (write-1 pulse, reads 0).
- 9: DIDX[5:0].
- 10: INTERVAL.
- 11: FCOUNT, read-only.
- 12-15: writes ignored, reads 0.
REQ-015 SHALL implement states IDLE, CLEAR and PENDING, with swap_pending high only in PENDING.
REQ-016 SHALL drive wr_ready as: 1 in IDLE; 0 in CLEAR and PENDING.
REQ-017 IDLE: an accepted write to 8 with bit2=1 SHALL enter CLEAR, and clear SHALL take priority over commit in the same write.
REQ-018 CLEAR: the block SHALL zero back rows 0..7, one row per cycle in ascending order, then return to IDLE, taking exactly 8 cycles.
REQ-019 IDLE: an accepted write to 8 with bit0=1 and bit2=0 SHALL enter PENDING on the next cycle.
REQ-020 PENDING: on the first cycle with frame_done=1, the block SHALL copy back to front, increment FCOUNT (modulo 256, wrapping 255->0) and return to IDLE.
REQ-021 A frame_done pulse in the same cycle as the accepted commit write SHALL not trigger the swap, and the swap SHALL occur on the next frame_done pulse.
REQ-022 Writes to CTRL SHALL update auto_swap from bit1 in every case.
REQ-023 Auto mode (auto_swap=1, state IDLE) SHALL be driven by a 8-bit interval counter ICNT:
- ICNT increments on each frame_done pulse.
- When ICNT == max(INTERVAL,1)-1, that pulse SHALL perform the copy and FCOUNT increment, and ICNT SHALL wrap to 0.
- INTERVAL=0 or 1 SHALL swap every frame.
REQ-024 A write accepted in the same cycle as an auto swap SHALL be applied to back only after the copy: front receives the pre-write back value.
REQ-025 Clearing auto_swap SHALL reset ICNT to 0.
REQ-026 In CLEAR and PENDING, ICNT SHALL hold.
REQ-027 frame_done pulses in CLEAR SHALL be ignored.
REQ-028 frame_out and done_index SHALL be registered outputs that change only on a swap or DIDX write respectively, never mid-frame from back-buffer writes.
REQ-029 rd_data SHALL return the back-buffer row for addresses 0-7, not the front.

Reset
REQ-030 With rst=1 at a clock edge, the block SHALL:
- set the state to IDLE;
- zero all back rows, front rows, DIDX, INTERVAL, FCOUNT and ICNT;
- set auto_swap=AUTO_DEFAULT.
REQ-031 During and after reset, outputs SHALL be frame_out=0, done_index=0, swap_pending=0 and wr_ready=1; wr_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-032 Reset asserted in CLEAR or PENDING SHALL abort the operation with no swap and no FCOUNT change.

Verification
REQ-033 Manual swap scenario: write rows 0..7 = 0x01..0x08, commit, then pulse frame_done -> frame_out=0x0807060504030201 the cycle after the pulse, FCOUNT=1, swap_pending=0.
REQ-034 Stall scenario: commit, hold wr_valid with addr 0 = 0xFF for 5 cycles before frame_done -> wr_ready=0 throughout, write is accepted the cycle after the swap, and front row0 is the old value.
REQ-035 Clear scenario: back rows = 0xAA, then write CTRL=0x05 -> wr_ready=0 for 8 cycles, all rows read 0, no PENDING entered.
REQ-036 Auto scenario: auto_swap=1 and INTERVAL=3, then pulse frame_done 7 times -> swaps on pulses 3 and 6, FCOUNT=2, ICNT=1.
REQ-037 Simultaneous-event scenario: commit write coincident with frame_done -> no swap that pulse, swap on the next pulse.
REQ-038 Reset-abort scenario: rst in PENDING -> swap_pending=0, frame_out=0 and FCOUNT=0 next cycle; a later frame_done causes no swap.
